sega_joy_scanner: RTL and testbench

- Parametrised multi-channel Sega pad scanner; next generation of the existing two-port 3-button joystick logic.
- Drives SEL on `NUM_CH` pads in lockstep, runs the 8-phase 6-button handshake and classifies each pad as none, 3-button or 6-button.
- Debounces the result over whole frames and publishes a 12-bit active-high status per channel, with a sticky change flag.
- Sits behind the ISA port decoder, which reads `status`, `pad_type` and `changed` and pulses `ack`.

---
 rtl/sega_joy_scanner.sv | 187 ++++++++++++++++++
 tb/tb_sega_joy_scanner.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sega_joy_scanner.sv
// ============================================================================
// Module   : sega_joy_scanner
// Purpose  : Multi-channel Sega pad scanner with 3/6-button detection,
//            whole-frame debounce and sticky per-channel change flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sega_joy_scanner #(
    parameter int NUM_CH       = 2,
    parameter int PHASE_CYCLES = 500,
    parameter int IDLE_CYCLES  = 850000,
    parameter int DEBOUNCE     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CH*6-1:0]  sj,
    output logic [NUM_CH-1:0]    sel,
    output logic [NUM_CH*12-1:0] status,
    output logic [NUM_CH*2-1:0]  pad_type,
    output logic [NUM_CH-1:0]    changed,
    input  logic [NUM_CH-1:0]    ack,
    output logic                 frame_done
);

    localparam int CNT_MAX = (PHASE_CYCLES > IDLE_CYCLES) ? PHASE_CYCLES : IDLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_CYCLES - 1);
    localparam int MC_W = $clog2(DEBOUNCE + 1);
    localparam logic [MC_W-1:0] MC_MAX = MC_W'(DEBOUNCE);
    localparam logic [MC_W-1:0] MC_ONE = MC_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         phase_q, phase_d;
    logic               sel_q, sel_d;
    logic               frame_done_q, frame_done_d;
    logic               sample;
    logic               commit;
    logic [NUM_CH*6-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            phase_q      <= '0;
            sel_q        <= 1'b1;
            frame_done_q <= 1'b0;
            sync1_q      <= '0;
            sync2_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            sel_q        <= sel_d;
            frame_done_q <= frame_done_d;
            sync1_q      <= sj;
            sync2_q      <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        phase_d = phase_q;
        sample  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cnt_q == IDLE_LAST) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                    phase_d = '0;
                end
            end
            ST_SCAN: begin
                if (cnt_q == PHASE_LAST) begin
                    sample = 1'b1;
                    cnt_d  = '0;
                    if (phase_q == 3'd7) begin
                        state_d = ST_COMMIT;
                    end else begin
                        phase_d = phase_q + 3'd1;
                    end
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // SEL and the strobe are derived from the next state so they leave a flop cleanly
        sel_d        = (state_d == ST_SCAN) ? ~phase_d[0] : 1'b1;
        frame_done_d = (state_d == ST_COMMIT);
    end

    assign commit     = (state_q == ST_COMMIT);
    assign sel        = {NUM_CH{sel_q}};
    assign frame_done = frame_done_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [5:0]     pins;
        logic [11:0]    cap_q;
        logic           present_q, six_q;
        logic [1:0]     prev_type_q, pub_type_q, res_type;
        logic [11:0]    prev_stat_q, pub_stat_q, res_stat;
        logic [MC_W-1:0] mcnt_q, mcnt_d;
        logic           changed_q, changed_d;
        logic           same, publish;

        assign pins = sync2_q[c*6 +: 6];

        always_comb begin
            res_type = 2'b00;
            res_stat = '0;
            if (present_q) begin
                if (six_q) begin
                    res_type = 2'b10;
                    res_stat = cap_q;
                end else begin
                    res_type = 2'b01;
                    res_stat = {4'h0, cap_q[7:0]};
                end
            end
            same    = (res_type == prev_type_q) && (res_stat == prev_stat_q);
            mcnt_d  = same ? ((mcnt_q == MC_MAX) ? MC_MAX : mcnt_q + 1'b1) : MC_ONE;
            publish = commit && (mcnt_d == MC_MAX) &&
                      ((res_type != pub_type_q) || (res_stat != pub_stat_q));
            // a publish in the same cycle as ack keeps the flag set
            changed_d = publish | (changed_q & ~ack[c]);
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cap_q       <= '0;
                present_q   <= 1'b0;
                six_q       <= 1'b0;
                prev_type_q <= '0;
                prev_stat_q <= '0;
                pub_type_q  <= '0;
                pub_stat_q  <= '0;
                mcnt_q      <= '0;
                changed_q   <= 1'b0;
            end else begin
                if (sample) begin
                    case (phase_q)
                        3'd0: cap_q[5:0] <= ~pins;
                        3'd1: begin
                            cap_q[7:6] <= ~pins[5:4];
                            present_q  <= ~pins[2] & ~pins[3];
                        end
                        3'd5: six_q <= (pins[3:0] == 4'b0000);
                        3'd6: cap_q[11:8] <= ~pins[3:0];
                        default: ;
                    endcase
                end
                if (commit) begin
                    prev_type_q <= res_type;
                    prev_stat_q <= res_stat;
                    mcnt_q      <= mcnt_d;
                    if (publish) begin
                        pub_type_q <= res_type;
                        pub_stat_q <= res_stat;
                    end
                end
                changed_q <= changed_d;
            end
        end

        assign status[c*12 +: 12] = pub_stat_q;
        assign pad_type[c*2 +: 2] = pub_type_q;
        assign changed[c]         = changed_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_sega_joy_scanner.sv
// ============================================================================
// Module   : tb_sega_joy_scanner
// Purpose  : Directed plus randomised bench for sega_joy_scanner with
//            behavioural 3/6-button pad models and a frame-level reference.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sega_joy_scanner;

    localparam int NUM_CH = 2;
    localparam int PH     = 4;
    localparam int IDLE   = 16;
    localparam int DEB    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] sj;
    logic [1:0]  sel;
    logic [23:0] status;
    logic [3:0]  pad_type;
    logic [1:0]  changed;
    logic [1:0]  ack;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int last_wait;

    sega_joy_scanner #(
        .NUM_CH(NUM_CH), .PHASE_CYCLES(PH), .IDLE_CYCLES(IDLE), .DEBOUNCE(DEB)
    ) dut (
        .clk(clk), .reset(reset), .sj(sj), .sel(sel), .status(status),
        .pad_type(pad_type), .changed(changed), .ack(ack), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Pad models: type 0 none, 1 three-button, 2 six-button; buttons active-high
    int          ptype [2] = '{0, 0};
    logic [11:0] pbtn  [2] = '{12'h0, 12'h0};
    int          pcnt  [2] = '{0, 0};
    int          quiet [2] = '{0, 0};
    logic        sel_prev [2] = '{1'b1, 1'b1};

    // six-button pad counts SEL transitions and forgets them after a quiet spell
    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            sel_prev[c] <= sel[c];
            if (sel[c] !== sel_prev[c]) begin
                pcnt[c]  <= pcnt[c] + 1;
                quiet[c] <= 0;
            end else begin
                if (quiet[c] < 1000) quiet[c] <= quiet[c] + 1;
                if (quiet[c] >= 10) pcnt[c] <= 0;
            end
        end
    end

    function automatic logic [5:0] pad_pins(int t, logic [11:0] b, logic s, int ph);
        if (t == 0) return 6'h3F;
        if (t == 2 && ph == 5) return {~b[7], ~b[6], 4'b0000};
        if (t == 2 && ph == 6) return {~b[5], ~b[4], ~b[11], ~b[10], ~b[9], ~b[8]};
        if (t == 2 && ph == 7) return {~b[7], ~b[6], 4'b1111};
        if (s) return ~b[5:0];
        return {~b[7], ~b[6], 2'b00, ~b[1], ~b[0]};
    endfunction

    always_comb begin
        sj = '1;
        for (int c = 0; c < 2; c++) begin
            sj[c*6 +: 6] = pad_pins(ptype[c], pbtn[c], sel[c],
                                    pcnt[c] + ((sel[c] !== sel_prev[c]) ? 1 : 0));
        end
    end

    // Reference: publish once the last DEB frame results agree and differ from the published one
    logic [13:0] hist [2][DEB];
    int          nfr  [2];
    logic [13:0] pub_m [2];
    logic        chg_m [2];

    function automatic logic [13:0] frame_res(int t, logic [11:0] b);
        if (t == 0) return 14'h0;
        if (t == 1) return {2'b01, 4'h0, b[7:0]};
        return {2'b10, b};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            nfr[c] = 0; pub_m[c] = '0; chg_m[c] = 1'b0;
            for (int i = 0; i < DEB; i++) hist[c][i] = '0;
        end
    endtask

    task automatic model_frame(input logic [1:0] ackm);
        for (int c = 0; c < 2; c++) begin
            logic [13:0] res;
            logic        all_eq, set;
            res = frame_res(ptype[c], pbtn[c]);
            for (int i = DEB - 1; i > 0; i--) hist[c][i] = hist[c][i-1];
            hist[c][0] = res;
            nfr[c]++;
            all_eq = (nfr[c] >= DEB);
            for (int i = 0; i < DEB; i++) if (hist[c][i] != res) all_eq = 1'b0;
            set = all_eq && (res != pub_m[c]);
            if (set) pub_m[c] = res;
            chg_m[c] = set | (chg_m[c] & ~ackm[c]);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        for (int c = 0; c < 2; c++) begin
            check($sformatf("status%0d", c), 32'(status[c*12 +: 12]), 32'(pub_m[c][11:0]));
            check($sformatf("pad_type%0d", c), 32'(pad_type[c*2 +: 2]), 32'(pub_m[c][13:12]));
            check($sformatf("changed%0d", c), 32'(changed[c]), 32'(chg_m[c]));
        end
        check("frame_done_pulse", 32'(frame_done), 32'(0));
    endtask

    // ackm is held high during the COMMIT cycle
    task automatic wait_frame(input logic [1:0] ackm);
        int n = 0;
        while (frame_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        last_wait = n;
        check("frame_done_seen", 32'(frame_done), 32'(1));
        ack = ackm;
        @(negedge clk);
        ack = 2'b00;
        model_frame(ackm);
        check_outputs();
    endtask

    task automatic pulse_ack(input logic [1:0] m);
        ack = m;
        @(negedge clk);
        ack = 2'b00;
        for (int c = 0; c < 2; c++) if (m[c]) chg_m[c] = 1'b0;
        check("changed_after_ack", 32'(changed), 32'({chg_m[1], chg_m[0]}));
    endtask

    initial begin
        int n;
        reset = 1'b1;
        ack   = 2'b00;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // 1: reset mid-SCAN
        n = 0;
        while (sel[0] !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        check("reached_scan", 32'(sel), 32'(0));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_sel", 32'(sel), 32'(2'b11));
        check("rst_status", 32'(status), 32'(0));
        check("rst_pad_type", 32'(pad_type), 32'(0));
        check("rst_changed", 32'(changed), 32'(0));
        check("rst_frame_done", 32'(frame_done), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        n = 1;
        while (sel[0] !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        check("first_sel_fall", 32'(n), 32'(IDLE + PH + 1));

        // 4: no pads for 5 frames, also checks the frame period
        for (int f = 0; f < 5; f++) begin
            wait_frame(2'b00);
            check("none_changed", 32'(changed), 32'(0));
            if (f > 0) check("frame_period", 32'(last_wait + 1), 32'(8*PH + IDLE + 1));
        end

        // 2: three-button pad with UP and B on ch0
        ptype[0] = 1; pbtn[0] = 12'h011;
        wait_frame(2'b00);
        check("deb_no_pub", 32'(changed), 32'(0));
        wait_frame(2'b00);
        check("ch0_status", 32'(status[11:0]), 32'(12'h011));
        check("ch0_type", 32'(pad_type[1:0]), 32'(2'b01));
        check("ch0_changed", 32'(changed), 32'(2'b01));
        pulse_ack(2'b01);

        // 3: six-button pad with X and START on ch1
        ptype[1] = 2; pbtn[1] = 12'h480;
        wait_frame(2'b00);
        wait_frame(2'b00);
        check("ch1_status", 32'(status[23:12]), 32'(12'h480));
        check("ch1_type", 32'(pad_type[3:2]), 32'(2'b10));
        check("ch1_changed", 32'(changed[1]), 32'(1));
        check("ch0_kept", 32'(status[11:0]), 32'(12'h011));

        // 5: one-frame glitch is filtered, two-frame hold publishes
        pulse_ack(2'b11);
        pbtn[0] = 12'h051;
        wait_frame(2'b00);
        pbtn[0] = 12'h011;
        wait_frame(2'b00);
        wait_frame(2'b00);
        check("glitch_changed", 32'(changed[0]), 32'(0));
        check("glitch_status", 32'(status[11:0]), 32'(12'h011));
        pbtn[0] = 12'h051;
        wait_frame(2'b00);
        wait_frame(2'b00);
        check("held_A", 32'(status[6]), 32'(1));

        // 6: ack coincident with publish, then ack on a clear flag
        pbtn[0] = 12'h011;
        wait_frame(2'b01);
        wait_frame(2'b01);
        check("set_wins", 32'(changed[0]), 32'(1));
        pulse_ack(2'b10);
        check("ack_clear_noop", 32'(changed), 32'(2'b01));

        // randomised frames
        for (int f = 0; f < 40; f++) begin
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(0, 2) == 0) begin
                    ptype[c] = int'($urandom_range(0, 2));
                    pbtn[c]  = 12'($urandom);
                    if (ptype[c] == 1 && pbtn[c][0] && pbtn[c][1]) pbtn[c][1] = 1'b0;
                end
            end
            if ($urandom_range(0, 3) == 0) pulse_ack(2'($urandom_range(0, 3)));
            wait_frame(2'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
